// File: rtl/if_id_queue_if.sv
// -----------------------------------------------------------------------------
// if_id_queue_if
// Handshake bundle between the fetch stage, the IF/ID queue and decode.
//   master : fetch/decode side (drives instr_in, pc_next_in, fetch_valid_in,
//            flush_in, decode_ready_in; observes the queue outputs)
//   slave  : the queue itself (the reverse directions)
// Optional: bubble_cnt_out exists only when IF_ID_QUEUE_BUBBLE_CNT_EN is defined.
// -----------------------------------------------------------------------------
interface if_id_queue_if;
   logic [15:0] instr_in;
   logic [15:0] pc_next_in;
   logic        fetch_valid_in;
   logic        fetch_ready_out;
   logic        flush_in;
   logic        decode_ready_in;
   logic [15:0] instr_out;
   logic [15:0] pc_next_out;
   logic        valid_out;
   logic [1:0]  count_out;
`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_out;
`endif

   modport master (
      output instr_in,
      output pc_next_in,
      output fetch_valid_in,
      output flush_in,
      output decode_ready_in,
      input  fetch_ready_out,
      input  instr_out,
      input  pc_next_out,
      input  valid_out,
      input  count_out
`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
      ,
      input  bubble_cnt_out
`endif
   );

   modport slave (
      input  instr_in,
      input  pc_next_in,
      input  fetch_valid_in,
      input  flush_in,
      input  decode_ready_in,
      output fetch_ready_out,
      output instr_out,
      output pc_next_out,
      output valid_out,
      output count_out
`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
      ,
      output bubble_cnt_out
`endif
   );
endinterface

// File: rtl/if_id_queue.sv
// -----------------------------------------------------------------------------
// if_id_queue
// Two-entry FIFO between fetch and decode holding {instr, pc_next} pairs.
// Ports:
//   clk  - clock, all state changes on the rising edge
//   rst  - synchronous active-low reset
//   q    - if_id_queue_if.slave: fetch inputs, flush, decode ready, head
//          outputs (instr_out / pc_next_out / valid_out), count_out and
//          fetch_ready_out
// Configuration: define IF_ID_QUEUE_BUBBLE_CNT_EN to add bubble_cnt_out, a
// saturating count of cycles where decode was ready but the queue was empty.
// -----------------------------------------------------------------------------
module if_id_queue (
   input  logic           clk,
   input  logic           rst,
   if_id_queue_if.slave   q
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } occ_e;

   localparam logic [15:0] NOP_INSTR = 16'h0800;

   occ_e        state_r;
   occ_e        state_nxt_s;
   logic        rd_ptr_r;
   logic        wr_ptr_r;
   logic        rd_nxt_s;
   logic        wr_nxt_s;
   logic [1:0]  count_r;
   logic [1:0]  count_nxt_s;
   logic        valid_r;
   logic [15:0] instr_r;
   logic [15:0] pc_r;
   logic [15:0] instr_nxt_s;
   logic [15:0] pc_nxt_s;
   logic [31:0] mem_r [0:1];
   logic        fetch_ready_s;
   logic        enq_s;
   logic        deq_s;

   // Ready depends only on registered occupancy so fetch never sees a path from decode.
   assign fetch_ready_s     = (count_r != 2'd2);
   assign enq_s             = q.fetch_valid_in & fetch_ready_s & ~q.flush_in;
   assign deq_s             = valid_r & q.decode_ready_in & ~q.flush_in;

   assign q.fetch_ready_out = fetch_ready_s;
   assign q.valid_out       = valid_r;
   assign q.instr_out       = instr_r;
   assign q.pc_next_out     = pc_r;
   assign q.count_out       = count_r;

   // Next occupancy state, pointers and the head word that will be visible after the edge.
   always_comb begin
      state_nxt_s = state_r;
      rd_nxt_s    = rd_ptr_r;
      wr_nxt_s    = wr_ptr_r;
      count_nxt_s = count_r;
      instr_nxt_s = NOP_INSTR;
      pc_nxt_s    = 16'h0000;

      if (q.flush_in) begin
         state_nxt_s = EMPTY;
         rd_nxt_s    = 1'b0;
         wr_nxt_s    = 1'b0;
      end else begin
         case (state_r)
            EMPTY: begin
               if (enq_s) begin
                  state_nxt_s = ONE;
               end else begin
                  state_nxt_s = EMPTY;
               end
            end
            ONE: begin
               if (enq_s && !deq_s) begin
                  state_nxt_s = FULL;
               end else if (deq_s && !enq_s) begin
                  state_nxt_s = EMPTY;
               end else begin
                  state_nxt_s = ONE;
               end
            end
            FULL: begin
               if (deq_s) begin
                  state_nxt_s = ONE;
               end else begin
                  state_nxt_s = FULL;
               end
            end
            default: begin
               state_nxt_s = EMPTY;
            end
         endcase
         // Pointers are one bit wide, so inversion is the wrap from 1 to 0.
         if (deq_s) begin
            rd_nxt_s = ~rd_ptr_r;
         end else begin
            rd_nxt_s = rd_ptr_r;
         end
         if (enq_s) begin
            wr_nxt_s = ~wr_ptr_r;
         end else begin
            wr_nxt_s = wr_ptr_r;
         end
      end

      case (state_nxt_s)
         EMPTY:   count_nxt_s = 2'd0;
         ONE:     count_nxt_s = 2'd1;
         FULL:    count_nxt_s = 2'd2;
         default: count_nxt_s = 2'd0;
      endcase

      // The incoming word becomes head only when it lands in the slot the
      // read pointer will point at (queue was empty, or ONE with enq+deq).
      if (state_nxt_s == EMPTY) begin
         instr_nxt_s = NOP_INSTR;
         pc_nxt_s    = 16'h0000;
      end else if (enq_s && (wr_ptr_r == rd_nxt_s)) begin
         instr_nxt_s = q.instr_in;
         pc_nxt_s    = q.pc_next_in;
      end else begin
         instr_nxt_s = mem_r[rd_nxt_s][31:16];
         pc_nxt_s    = mem_r[rd_nxt_s][15:0];
      end
   end

   // Occupancy FSM with registered head, valid and count outputs.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r  <= EMPTY;
         rd_ptr_r <= 1'b0;
         wr_ptr_r <= 1'b0;
         count_r  <= 2'd0;
         valid_r  <= 1'b0;
         instr_r  <= NOP_INSTR;
         pc_r     <= 16'h0000;
      end else begin
         state_r  <= state_nxt_s;
         rd_ptr_r <= rd_nxt_s;
         wr_ptr_r <= wr_nxt_s;
         count_r  <= count_nxt_s;
         valid_r  <= (state_nxt_s != EMPTY);
         instr_r  <= instr_nxt_s;
         pc_r     <= pc_nxt_s;
      end
   end

   // Entry storage; contents are don't-care whenever the slot is not occupied.
   always_ff @(posedge clk) begin
      if (rst && enq_s) begin
         mem_r[wr_ptr_r] <= {q.instr_in, q.pc_next_in};
      end else begin
         mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
   end

`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
   logic [15:0] bubble_cnt_r;
   logic        bubble_s;

   assign bubble_s         = q.decode_ready_in & (count_r == 2'd0) & ~q.flush_in;
   assign q.bubble_cnt_out = bubble_cnt_r;

   // Saturating count of decode-ready cycles that found the queue empty.
   always_ff @(posedge clk) begin
      if (!rst) begin
         bubble_cnt_r <= 16'h0000;
      end else if (bubble_s && (bubble_cnt_r != 16'hFFFF)) begin
         bubble_cnt_r <= bubble_cnt_r + 16'd1;
      end else begin
         bubble_cnt_r <= bubble_cnt_r;
      end
   end
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// -----------------------------------------------------------------------------
// tb_if_id_queue
// Self-checking bench for if_id_queue. A queue of {instr, pc_next} words is
// the reference model; each tick applies the handshake rules to it, then the
// DUT outputs are compared one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_if_id_queue;

   logic clk;
   logic rst;
   if_id_queue_if bus ();

   if_id_queue dut (
      .clk (clk),
      .rst (rst),
      .q   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          checks;
   int          errors;
   logic [31:0] mq [$];
   logic [15:0] m_bub;

   function automatic logic [15:0] exp_instr();
      logic [31:0] h;
      if (mq.size() == 0) return 16'h0800;
      h = mq[0];
      return h[31:16];
   endfunction

   function automatic logic [15:0] exp_pc();
      logic [31:0] h;
      if (mq.size() == 0) return 16'h0000;
      h = mq[0];
      return h[15:0];
   endfunction

   // Advance the reference model with the current inputs, then one clock edge.
   task automatic tick();
      bit e;
      bit d;
      if (!rst) begin
         mq.delete();
         m_bub = 16'h0000;
      end else begin
         e = bus.fetch_valid_in && (mq.size() < 2) && !bus.flush_in;
         d = (mq.size() > 0) && bus.decode_ready_in && !bus.flush_in;
         if (bus.decode_ready_in && (mq.size() == 0) && !bus.flush_in && (m_bub != 16'hFFFF))
            m_bub = m_bub + 16'd1;
         if (bus.flush_in) begin
            mq.delete();
         end else begin
            if (d) void'(mq.pop_front());
            if (e) mq.push_back({bus.instr_in, bus.pc_next_in});
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit fv, input logic [15:0] ins, input logic [15:0] pc,
                        input bit dr, input bit fl);
      bus.fetch_valid_in  = fv;
      bus.instr_in        = ins;
      bus.pc_next_in      = pc;
      bus.decode_ready_in = dr;
      bus.flush_in        = fl;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b1, 1'b0);
      tick();
      checks++; if (bus.valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.valid_out); end
      checks++; if (bus.instr_out !== 16'h0800) begin errors++; $display("FAIL reset_instr got %h want 0800", bus.instr_out); end
      checks++; if (bus.pc_next_out !== 16'h0000) begin errors++; $display("FAIL reset_pc got %h want 0000", bus.pc_next_out); end
      checks++; if (bus.fetch_ready_out !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", bus.fetch_ready_out); end
      checks++; if (bus.count_out !== 2'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count_out); end
      rst = 1'b1;
   endtask

   task automatic test_fill();
      drive(1'b1, 16'h1234, 16'h0002, 1'b0, 1'b0);
      tick();
      checks++; if (bus.instr_out !== 16'h1234 || bus.count_out !== 2'd1) begin errors++; $display("FAIL fill_first got %h/%0d want 1234/1", bus.instr_out, bus.count_out); end
      drive(1'b1, 16'h5678, 16'h0004, 1'b0, 1'b0);
      tick();
      checks++; if (bus.count_out !== 2'd2) begin errors++; $display("FAIL fill_count got %0d want 2", bus.count_out); end
      checks++; if (bus.fetch_ready_out !== 1'b0) begin errors++; $display("FAIL fill_ready got %0b want 0", bus.fetch_ready_out); end
      checks++; if (bus.instr_out !== 16'h1234) begin errors++; $display("FAIL fill_head got %h want 1234", bus.instr_out); end
      // Third offer while FULL, also with decode ready: must be refused.
      drive(1'b1, 16'h9ABC, 16'h0006, 1'b0, 1'b0);
      tick();
      checks++; if (bus.count_out !== 2'd2 || bus.instr_out !== 16'h1234) begin errors++; $display("FAIL fill_refuse got %h/%0d want 1234/2", bus.instr_out, bus.count_out); end
      drive(1'b1, 16'h9ABC, 16'h0006, 1'b1, 1'b0);
      tick();
      checks++; if (bus.count_out !== 2'd1 || bus.instr_out !== 16'h5678) begin errors++; $display("FAIL full_deq_refuse got %h/%0d want 5678/1", bus.instr_out, bus.count_out); end
      // Put the FULL state back for the drain test.
      drive(1'b1, 16'hABCD, 16'h0008, 1'b0, 1'b0);
      tick();
   endtask

   task automatic test_drain();
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      checks++; if (bus.instr_out !== 16'h5678 || bus.pc_next_out !== 16'h0004) begin errors++; $display("FAIL drain_0 got %h/%h want 5678/0004", bus.instr_out, bus.pc_next_out); end
      tick();
      checks++; if (bus.instr_out !== 16'hABCD || bus.pc_next_out !== 16'h0008) begin errors++; $display("FAIL drain_1 got %h/%h want abcd/0008", bus.instr_out, bus.pc_next_out); end
      tick();
      checks++; if (bus.instr_out !== 16'h0800 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL drain_2 got %h/%0b want 0800/0", bus.instr_out, bus.valid_out); end
      // Decode ready on an empty queue must not disturb anything.
      tick();
      checks++; if (bus.count_out !== 2'd0 || bus.fetch_ready_out !== 1'b1) begin errors++; $display("FAIL empty_deq got %0d/%0b want 0/1", bus.count_out, bus.fetch_ready_out); end
   endtask

   task automatic test_flush();
      drive(1'b1, 16'h1111, 16'h0010, 1'b0, 1'b0);
      tick();
      drive(1'b1, 16'h2222, 16'h0012, 1'b1, 1'b1);
      tick();
      checks++; if (bus.count_out !== 2'd0 || bus.valid_out !== 1'b0) begin errors++; $display("FAIL flush_empty got %0d/%0b want 0/0", bus.count_out, bus.valid_out); end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      checks++; if (bus.count_out !== 2'd0 || bus.instr_out !== 16'h0800) begin errors++; $display("FAIL flush_nostore got %h/%0d want 0800/0", bus.instr_out, bus.count_out); end
   endtask

   task automatic test_stream();
      drive(1'b1, 16'h4000, 16'h0000, 1'b0, 1'b0);
      tick();
      for (int i = 1; i <= 8; i++) begin
         drive(1'b1, 16'h4000 + 16'(i), 16'(2 * i), 1'b1, 1'b0);
         tick();
         checks++; if (bus.count_out !== 2'd1 || bus.pc_next_out !== 16'(2 * i)) begin errors++; $display("FAIL stream_%0d got pc %h cnt %0d want %h/1", i, bus.pc_next_out, bus.count_out, 16'(2 * i)); end
      end
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1);
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         rst = ($urandom_range(0, 29) != 0);
         drive($urandom_range(0, 3) != 0, 16'($urandom), 16'($urandom),
               $urandom_range(0, 1) == 1, $urandom_range(0, 11) == 0);
         tick();
         checks++;
         if (bus.valid_out !== (mq.size() != 0) || bus.count_out !== 2'(mq.size()) ||
             bus.fetch_ready_out !== (mq.size() != 2) || bus.instr_out !== exp_instr() ||
             bus.pc_next_out !== exp_pc()) begin
            errors++;
            $display("FAIL random_%0d got v%0b c%0d r%0b %h/%h want v%0b c%0d r%0b %h/%h", i,
                     bus.valid_out, bus.count_out, bus.fetch_ready_out, bus.instr_out, bus.pc_next_out,
                     mq.size() != 0, mq.size(), mq.size() != 2, exp_instr(), exp_pc());
         end
`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
         checks++; if (bus.bubble_cnt_out !== m_bub) begin errors++; $display("FAIL random_bubble_%0d got %0d want %0d", i, bus.bubble_cnt_out, m_bub); end
`endif
      end
      rst = 1'b1;
   endtask

`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
   task automatic test_bubble();
      rst = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      tick();
      rst = 1'b1;
      drive(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0);
      tick(); tick(); tick();
      checks++; if (bus.bubble_cnt_out !== 16'd3) begin errors++; $display("FAIL bubble_three got %0d want 3", bus.bubble_cnt_out); end
      rst = 1'b0;
      tick();
      checks++; if (bus.bubble_cnt_out !== 16'd0) begin errors++; $display("FAIL bubble_reset got %0d want 0", bus.bubble_cnt_out); end
      rst = 1'b1;
   endtask
`endif

   initial begin
      checks = 0;
      errors = 0;
      m_bub  = 16'h0000;
      rst    = 1'b0;
      drive(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_flush();
      test_stream();
`ifdef IF_ID_QUEUE_BUBBLE_CNT_EN
      test_bubble();
`endif
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
